// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP-RISC ALU shift path: operand sizes,
// sequencer state encoding and shift-mode constants.
package kgp_alu_pkg;

    localparam int KGP_WIDTH   = 32;
    localparam int KGP_SHAMT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shr_state_t;

    localparam logic SHR_LOGICAL = 1'b0;
    localparam logic SHR_ARITH   = 1'b1;

endpackage

// File: rtl/shr_step.sv
// Combinational right step by one or two positions.
// The fill bit is the operand sign bit in arithmetic mode and zero otherwise.
module shr_step
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = KGP_WIDTH
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             mode,
    input  logic             two_step,
    output logic [WIDTH-1:0] result
);

    logic fill;

    always_comb begin
        fill = (mode == SHR_ARITH) ? operand[WIDTH-1] : 1'b0;
        if (two_step) begin
            result = {fill, fill, operand[WIDTH-1:2]};
        end else begin
            result = {fill, operand[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle logical/arithmetic right shifter with a start/busy/done handshake.
// Defining SHR_DUAL_STEP_EN retires two bit positions per cycle where possible.
module seq_shift_right
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH   = KGP_WIDTH,
    parameter int SHAMT_W = KGP_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic               done
);

    shr_state_t         state;
    shr_state_t         next_state;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] cnt_dec;
    logic               mode;
    logic               load;
    logic               step;
    logic               finish;
    logic               two_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath controls; the step size shrinks to one for the last odd bit.
    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == SHIFT) && (cnt != '0);
        finish = (state == SHIFT) && (cnt == '0);
`ifdef SHR_DUAL_STEP_EN
        two_step = (cnt >= SHAMT_W'(2));
`else
        two_step = 1'b0;
`endif
        cnt_dec = two_step ? SHAMT_W'(2) : SHAMT_W'(1);
    end

    assign busy = (state == SHIFT);

    shr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .operand (sreg),
        .mode    (mode),
        .two_step(two_step),
        .result  (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            cnt      <= '0;
            mode     <= SHR_LOGICAL;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sreg <= in_data;
                cnt  <= shamt;
                mode <= arith;
            end else if (step) begin
                sreg <= step_out;
                cnt  <= cnt - cnt_dec;
            end else if (finish) begin
                out_data <= sreg;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_right.sv
// Self-checking bench for seq_shift_right: directed vector table, hand-written
// corner sequences and randomized operations against a plain-arithmetic model.
module tb_seq_shift_right;
    import kgp_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in_data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] expect_out;
    } vec_t;

    seq_shift_right dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_data (in_data),
        .shamt   (shamt),
        .arith   (arith),
        .out_data(out_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sh, input logic ar);
        if (ar) return 32'($signed(v) >>> sh);
        return v >> sh;
    endfunction

    function automatic int ref_latency(input int sh);
`ifdef SHR_DUAL_STEP_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    // Called #1 after a clock edge; returns #1 after the edge that raised done.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic a);
        logic [31:0] held;
        logic [31:0] exp_out;
        int cycles;
        int busy_bad;
        int hold_bad;
        held     = out_data;
        exp_out  = ref_shift(d, int'(s), a);
        cycles   = 0;
        busy_bad = 0;
        hold_bad = 0;
        start = 1'b1; in_data = d; shamt = s; arith = a;
        @(posedge clk); #1;
        start = 1'b0; in_data = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
        while (done !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1) busy_bad++;
            if (out_data !== held) hold_bad++;
            @(posedge clk); #1;
            cycles++;
        end
        check({name, " latency"}, 32'(cycles), 32'(ref_latency(int'(s))));
        check({name, " out_data"}, out_data, exp_out);
        check({name, " busy_in_flight"}, 32'(busy_bad), 32'd0);
        check({name, " out_held"}, 32'(hold_bad), 32'd0);
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int dones;
        logic [31:0] captured;

        vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{32'hF000_0010, 5'd4,  1'b1, 32'hFF00_0001};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
        vecs[4] = '{32'h0000_0104, 5'd2,  1'b0, 32'h0000_0041};
        vecs[5] = '{32'h7FFF_FFFF, 5'd30, 1'b1, 32'h0000_0001};

        rst_n = 1'b0; start = 1'b0; in_data = '0; shamt = '0; arith = 1'b0;
        #2;
        check("reset out_data", out_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].sh, vecs[i].ar);
            check($sformatf("vec%0d table", i), out_data, vecs[i].expect_out);
        end

        // Second start while busy must be ignored.
        start = 1'b1; in_data = 32'hFFFF_0000; shamt = 5'd8; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; in_data = 32'h1234_5678; shamt = 5'd1; arith = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        captured = '0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) begin
                if (dones == 0) captured = out_data;
                dones++;
            end
            @(posedge clk); #1;
        end
        check("ignore_start done_count", 32'(dones), 32'd1);
        check("ignore_start out_data", captured, 32'h00FF_FF00);

        // Asynchronous reset in the middle of a long operation.
        start = 1'b1; in_data = 32'hABCD_EF01; shamt = 5'd20; arith = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort out_data", out_data, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("abort spurious_done", 32'(dones), 32'd0);
        run_op("after_abort", 32'h8765_4321, 5'd5, 1'b1);

        // Back-to-back: new start issued in the done cycle.
        run_op("b2b_first", 32'hFFFF_0000, 5'd8, 1'b0);
        run_op("b2b_second", 32'h0000_00F0, 5'd4, 1'b0);
        check("b2b_second value", out_data, 32'h0000_000F);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (i % 4 == 0) #0;
            run_op($sformatf("rand%0d", i), $urandom, 5'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
